// File: rtl/dist_min_sel.sv
// dist_min_sel: streaming nearest-candidate selector.
// Takes a batch of candidate cells and returns the distance to the goal and the
// in-batch index of the first closest candidate, plus count and overflow flags.
// Optional build macro DIST_MIN_CHEBYSHEV_EN: rank by max(|dx|,|dy|) instead of
// the Manhattan sum. Ports, latency and handshake are the same in both builds.
module dist_min_sel #(
  parameter int W    = 10,
  parameter int IDXW = 2
) (
  input  logic            m_clock,
  input  logic            p_reset,
  input  logic [W-1:0]    goal_x,
  input  logic [W-1:0]    goal_y,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_x,
  input  logic [W-1:0]    in_y,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W:0]      out_dist,
  output logic [IDXW-1:0] out_idx,
  output logic [IDXW:0]   out_count,
  output logic            out_ovf
);

  localparam int unsigned     NMAX = 1 << IDXW;
  localparam logic [IDXW:0]   CMAX = NMAX[IDXW:0];

  // |a-b| computed in W+1 bits so the difference never wraps
  function automatic logic [W:0] absdiff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[W] ? (~d + 1'b1) : d;
  endfunction

  logic            busy;
  logic            accept;
  logic [IDXW:0]   cnt;       // index of next accepted candidate, saturates at CMAX
  logic            bovf;      // batch already spilled past CMAX candidates
  logic            cnt_full;

  logic            s1_vld, s1_rank, s1_first, s1_last, s1_ovf;
  logic [W:0]      s1_adx, s1_ady;
  logic [IDXW-1:0] s1_idx;
  logic [IDXW:0]   s1_cnt;

  logic            s2_vld, s2_rank, s2_first, s2_last, s2_ovf;
  logic [W:0]      s2_dist;
  logic [IDXW-1:0] s2_idx;
  logic [IDXW:0]   s2_cnt;

  logic [W:0]      min_d, nxt_d, dist_c;
  logic [IDXW-1:0] min_idx, nxt_idx;
  logic            take;

  assign in_ready = ~busy;
  assign accept   = in_valid & ~busy;
  assign cnt_full = (cnt == CMAX);

  // Batch bookkeeping: index counter and overflow, re-armed on the last accept
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      cnt  <= '0;
      bovf <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        cnt  <= '0;
        bovf <= 1'b0;
      end else begin
        cnt  <= cnt_full ? cnt : cnt + 1'b1;
        bovf <= bovf | cnt_full;
      end
    end
  end

  // Stage 1: absolute differences plus the candidate's batch metadata
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      s1_vld <= 1'b0; s1_rank <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
      s1_ovf <= 1'b0; s1_adx <= '0; s1_ady <= '0; s1_idx <= '0; s1_cnt <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_adx   <= absdiff(in_x, goal_x);
        s1_ady   <= absdiff(in_y, goal_y);
        s1_idx   <= cnt[IDXW-1:0];
        s1_rank  <= ~cnt[IDXW];
        s1_first <= (cnt == '0);
        s1_last  <= in_last;
        s1_cnt   <= cnt_full ? CMAX : cnt + 1'b1;
        s1_ovf   <= bovf | cnt_full;
      end
    end
  end

`ifdef DIST_MIN_CHEBYSHEV_EN
  assign dist_c = (s1_adx > s1_ady) ? s1_adx : s1_ady;
`else
  assign dist_c = s1_adx + s1_ady;
`endif

  // Stage 2: distance register
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      s2_vld <= 1'b0; s2_rank <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0;
      s2_ovf <= 1'b0; s2_dist <= '0; s2_idx <= '0; s2_cnt <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_dist  <= dist_c;
        s2_idx   <= s1_idx;
        s2_rank  <= s1_rank;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_cnt   <= s1_cnt;
        s2_ovf   <= s1_ovf;
      end
    end
  end

  // Running minimum: first candidate seeds it, strict-less keeps the earlier index on ties
  always_comb begin
    take    = s2_vld & s2_rank & (s2_first | (s2_dist < min_d));
    nxt_d   = take ? s2_dist : min_d;
    nxt_idx = take ? s2_idx  : min_idx;
  end

  // Minimum tracker and result registers; result holds until the consumer takes it
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      min_d     <= '0;
      min_idx   <= '0;
      out_valid <= 1'b0;
      out_dist  <= '0;
      out_idx   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (s2_vld) begin
        min_d   <= nxt_d;
        min_idx <= nxt_idx;
      end
      if (s2_vld && s2_last) begin
        out_valid <= 1'b1;
        out_dist  <= nxt_d;
        out_idx   <= nxt_idx;
        out_count <= s2_cnt;
        out_ovf   <= s2_ovf;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Input gate: closed from the last accept until the result is handed off
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset)                 busy <= 1'b0;
    else if (accept && in_last)  busy <= 1'b1;
    else if (out_valid && out_ready) busy <= 1'b0;
  end

endmodule
